// File: rtl/rca_seq_add_ctrl_pkg.sv
// Shared definitions for multi-cycle arithmetic controllers: FSM encodings and
// the chunk-count / counter-width derivation.
package rca_seq_add_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Number of slice passes needed to cover a full-width operand.
    function automatic int nchunk_of(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter wide enough to index every chunk, never narrower than one bit.
    function automatic int cnt_w_of(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/rca_seq_add_ctrl_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from full adders; the
// controller time-shares one instance across all chunks of an operation.
module rca_slice #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out
);

    logic [CHUNK:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[CHUNK];

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Multi-cycle add/subtract controller: one CHUNK-bit slice processes a WIDTH-bit
// operation LSB chunk first, with the carry registered between chunks.
module rca_seq_add_ctrl
    import rca_seq_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             overflow
);

    localparam int NCHUNK = nchunk_of(WIDTH, CHUNK);
    localparam int CW     = cnt_w_of(NCHUNK);

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
        $error("rca_seq_add_ctrl: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state;
    logic [CW-1:0]    count;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] sum;
    logic             co;
    logic             last;
    logic             accept;

    function automatic logic ovf_flag(input logic a_msb, input logic b_msb,
                                      input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last   = (count == CW'(NCHUNK - 1));
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (count == CW'(i)) begin
                a_sl = a_r[i*CHUNK +: CHUNK];
                b_sl = b_r[i*CHUNK +: CHUNK];
            end
        end
    end

    rca_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a     (a_sl),
        .b     (b_sl),
        .c_in  (carry),
        .s     (sum),
        .c_out (co)
    );

    // Operands are pure data: captured on accept, subtrahend pre-inverted.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= sub ? ~b : b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            carry    <= 1'b0;
            s        <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        carry    <= sub;
                        count    <= '0;
                        s        <= '0;
                        c_out    <= 1'b0;
                        overflow <= 1'b0;
                        state    <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (count == CW'(i)) begin
                            s[i*CHUNK +: CHUNK] <= sum;
                        end
                    end
                    carry <= co;
                    count <= count + CW'(1);
                    if (last) begin
                        c_out    <= co;
                        overflow <= ovf_flag(a_r[WIDTH-1], b_r[WIDTH-1], sum[CHUNK-1]);
                        state    <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Directed and randomised bench for rca_seq_add_ctrl at CHUNK = 8, 16, 32, 64.
module tb_rca_seq_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] s;
    logic        c_out;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    localparam int NSW = 4;
    logic [NSW-1:0]       sw_busy;
    logic [NSW-1:0]       sw_done;
    logic [NSW-1:0]       sw_c;
    logic [NSW-1:0]       sw_ov;
    logic [NSW-1:0][63:0] sw_s;

    always #5 clk = ~clk;

    rca_seq_add_ctrl #(
        .WIDTH (64),
        .CHUNK (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .s        (s),
        .c_out    (c_out),
        .overflow (overflow)
    );

    for (genvar g = 0; g < NSW; g++) begin : g_sweep
        rca_seq_add_ctrl #(
            .WIDTH (64),
            .CHUNK (8 << g)
        ) u_sw (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .sub      (sub),
            .a        (a),
            .b        (b),
            .busy     (sw_busy[g]),
            .done     (sw_done[g]),
            .s        (sw_s[g]),
            .c_out    (sw_c[g]),
            .overflow (sw_ov[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] av, input logic [63:0] bv, input logic sv);
        a = av;
        b = bv;
        sub = sv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, c_out, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/c_out/ovf=%b, want 0000",
                     {busy, done, c_out, overflow});
        end
        checks++;
        if (s !== 64'h0) begin
            errors++;
            $display("FAIL reset_s: got %h, want 0", s);
        end
    endtask

    task automatic test_full_carry();
        accept(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL carry_run_cycle%0d: got busy/done=%b, want 10", k, {busy, done});
            end
            tick();
        end
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL carry_done_edge4: got busy/done=%b, want 01", {busy, done});
        end
        checks++;
        if ({s, c_out, overflow} !== {64'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL carry_result: got s=%h c=%b ov=%b, want s=0 c=1 ov=0", s, c_out, overflow);
        end
        tick();
        checks++;
        if ({done, s} !== {1'b0, 64'h0}) begin
            errors++;
            $display("FAIL carry_hold: got done=%b s=%h, want done=0 s=0", done, s);
        end
    endtask

    task automatic test_overflow_add();
        int cyc;
        accept(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL ovf_latency: got %0d edges, want 4", cyc);
        end
        checks++;
        if ({s, c_out, overflow} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_add: got s=%h c=%b ov=%b, want s=8000000000000000 c=0 ov=1",
                     s, c_out, overflow);
        end
    endtask

    task automatic test_sub();
        int cyc;
        accept(64'd5, 64'd7, 1'b1);
        wait_done(cyc);
        checks++;
        if ({s, c_out, overflow} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_5_7: got s=%h c=%b ov=%b, want s=fffffffffffffffe c=0 ov=0",
                     s, c_out, overflow);
        end
        accept(64'h8000_0000_0000_0000, 64'h1, 1'b1);
        wait_done(cyc);
        checks++;
        if ({s, c_out, overflow} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_min_1: got s=%h c=%b ov=%b, want s=7fffffffffffffff c=1 ov=1",
                     s, c_out, overflow);
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        int stray;
        accept(64'd10, 64'd20, 1'b0);
        tick();
        a = 64'd1;
        b = 64'd1;
        sub = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL ign_latency: got %0d more edges, want 2", cyc);
        end
        checks++;
        if ({s, c_out, overflow} !== {64'd30, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ign_result: got s=%h c=%b ov=%b, want s=1e c=0 ov=0", s, c_out, overflow);
        end
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL ign_second_op: got %0d active cycles, want 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int pulses;
        accept(64'h1234, 64'h1111, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, c_out, overflow, s} !== 68'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got busy=%b done=%b c=%b ov=%b s=%h, want all 0",
                     busy, done, c_out, overflow, s);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d done cycles, want 0", pulses);
        end
        accept(64'd3, 64'd4, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc != 4 || s !== 64'd7) begin
            errors++;
            $display("FAIL midrst_next_op: got edges=%0d s=%h, want edges=4 s=7", cyc, s);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        a = 64'd1;
        b = 64'd2;
        sub = 1'b0;
        start = 1'b1;
        tick();
        wait_done(cyc);
        checks++;
        if (cyc != 4 || s !== 64'd3) begin
            errors++;
            $display("FAIL b2b_first: got edges=%0d s=%h, want edges=4 s=3", cyc, s);
        end
        a = 64'd100;
        b = 64'd23;
        wait_done(cyc);
        start = 1'b0;
        checks++;
        if (cyc != 5 || s !== 64'd123) begin
            errors++;
            $display("FAIL b2b_second: got done gap=%0d s=%h, want gap=5 s=7b", cyc, s);
        end
        tick();
        tick();
    endtask

    task automatic test_sweep();
        logic [63:0] av;
        logic [63:0] bv;
        logic        sv;
        logic [64:0] r;
        logic [63:0] s_exp;
        logic        c_exp;
        logic        o_exp;
        int          nch;
        int          stray;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 1004; n++) begin
            case (n)
                0: begin av = 64'hFFFF_FFFF_FFFF_FFFF; bv = 64'h1; sv = 1'b0; end
                1: begin av = 64'h7FFF_FFFF_FFFF_FFFF; bv = 64'h1; sv = 1'b0; end
                2: begin av = 64'd5; bv = 64'd7; sv = 1'b1; end
                3: begin av = 64'h8000_0000_0000_0000; bv = 64'h1; sv = 1'b1; end
                default: begin
                    av = {$urandom, $urandom};
                    bv = {$urandom, $urandom};
                    sv = 1'($urandom_range(0, 1));
                end
            endcase
            if (sv) begin
                r     = {1'b0, av} - {1'b0, bv};
                s_exp = r[63:0];
                c_exp = (av >= bv);
                o_exp = (av[63] != bv[63]) && (s_exp[63] != av[63]);
            end else begin
                r     = {1'b0, av} + {1'b0, bv};
                s_exp = r[63:0];
                c_exp = r[64];
                o_exp = (av[63] == bv[63]) && (s_exp[63] != av[63]);
            end
            accept(av, bv, sv);
            stray = 0;
            for (int k = 1; k <= 9; k++) begin
                tick();
                for (int g = 0; g < NSW; g++) begin
                    nch = 8 >> g;
                    if (k == nch) begin
                        checks++;
                        if (sw_done[g] !== 1'b1 || {sw_s[g], sw_c[g], sw_ov[g]} !== {s_exp, c_exp, o_exp}) begin
                            errors++;
                            $display("FAIL sweep_chunk%0d op%0d: got done=%b s=%h c=%b ov=%b, want done=1 s=%h c=%b ov=%b",
                                     8 << g, n, sw_done[g], sw_s[g], sw_c[g], sw_ov[g], s_exp, c_exp, o_exp);
                        end
                    end else if (sw_done[g] !== 1'b0) begin
                        stray++;
                    end
                end
            end
            checks++;
            if (stray != 0) begin
                errors++;
                $display("FAIL sweep_done_timing op%0d: got %0d off-cycle done pulses, want 0", n, stray);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_carry();
        test_overflow_add();
        test_sub();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
